fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch program counter and sequences the fetch stage: boot, sequential fetch, stall hold, redirect with a one-cycle bubble, and halt/resume.
- Sits between the execute-stage redirect and the decode-stage stall/halt signals, and drives the instruction-memory address.
- Provides a 1-bit epoch that toggles on every redirect, so downstream stages can discard wrong-path instructions.

Parameters:
- WIDTH, 32, PC and redirect target width in bits.
- RESET_PC, 0, PC value loaded at reset.
- INSTR_BYTES, 4, PC increment per fetch. Must be a power of two; redirect targets are aligned to it.

Ports:
- clock  input  1  Rising-edge clock.
- reset  input  1  Asynchronous, active-low reset (asserted when 0).
- start  input  1  Level. Leaves IDLE or HALT and begins fetching.
- stall  input  1  From decode. Holds the PC.
- redirectValid  input  1  From execute. Takes the jump this cycle.
- redirectTarget  input  WIDTH  Jump target address.
- halt  input  1  From decode. A halt instruction has been decoded.
- pc  output  WIDTH  Fetch address to instruction memory.
- pcEpoch  output  1  Toggles on each accepted redirect.
- fetchValid  output  1  pc is a live fetch this cycle.
- flush  output  1  One-cycle pulse the cycle after an accepted redirect.
- misaligned  output  1  One-cycle pulse: the accepted redirect target had nonzero low bits.
- fetchCount  output  32  Number of fetches consumed.
- state  output  2  IDLE=0, RUN=1, REDIRECT=2, HALT=3.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, pc=RESET_PC, pcEpoch=0, fetchValid=0, flush=0, misaligned=0, fetchCount=0.
  - Deassertion takes effect at the next rising clock edge.
  - Reset mid-operation discards everything in flight, including any pending redirect.
- All outputs are registered. fetchValid=1 exactly when state==RUN.
- A redirect is accepted when redirectValid=1 in RUN, REDIRECT or HALT. On acceptance at edge N:
  - pc <= redirectTarget with its low log2(INSTR_BYTES) bits cleared;
  - pcEpoch toggles;
  - flush=1 during cycle N+1;
  - misaligned=1 during cycle N+1 if any cleared bit was set;
  - state <= REDIRECT.
- Redirect has highest priority: over stall, over halt, over start.
- IDLE:
  - start=1 -> RUN at the next edge with pc unchanged.
  - redirectValid is ignored. stall and halt are ignored.
- RUN, with no redirect:
  - halt=1 -> HALT, pc held.
  - Otherwise, if stall=1 -> pc held.
  - Otherwise pc <= pc + INSTR_BYTES, wrapping mod 2^WIDTH, and fetchCount increments (wrapping mod 2^32).
  - A fetch is counted only when RUN, stall=0, halt=0 and redirectValid=0.
- REDIRECT: single bubble cycle, fetchValid=0.
  - Next edge -> RUN with pc held at the target, regardless of stall.
  - A further redirect re-enters REDIRECT with the new target and toggles the epoch again.
- HALT: fetchValid=0, pc held.
  - start=1 -> RUN at the same pc.
  - A redirect is accepted: the halt was on the wrong path.
  - halt is ignored.
- flush and misaligned are 0 in every cycle except the one following an accepted redirect.
- Latency:
  - Redirect at edge N -> pc=target with fetchValid=0 in cycle N+1.
  - Cycle N+2: fetchValid=1 at the target.
  - Cycle N+3: target+INSTR_BYTES if not stalled.

Test Plan:
- Reset, then start=1 for one cycle, stall=0 for 4 cycles -> pc sequence 0,0,4,8,12; fetchValid 0,1,1,1,1; fetchCount=3 at the end.
- In RUN at pc=0x10, stall=1 for 3 cycles -> pc stays 0x10, fetchValid stays 1, fetchCount is unchanged; release -> pc=0x14.
- In RUN at pc=0x20, redirectValid=1 with target 0x102 and stall=1 in the same cycle -> next cycle pc=0x100, state=REDIRECT, fetchValid=0, flush=1, misaligned=1, pcEpoch toggled. Following cycle: RUN at pc=0x100.
- Redirects on two consecutive cycles (0x40, then 0x80) -> pcEpoch toggles twice; pc=0x80; only one RUN entry, at 0x80.
- halt at pc=0x30 -> HALT with pc=0x30; redirect to 0x50 -> REDIRECT then RUN at 0x50. Separately: halt, then start -> RUN resumes at 0x30.
- WIDTH=32 with pc=0xFFFFFFFC, no stall -> pc wraps to 0. Assert reset mid-REDIRECT -> all outputs immediately return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC owner sequencing boot, sequential fetch, stall, redirect bubble and halt/resume.
module fetch_sequencer #(
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             redirectValid,
    input  logic [WIDTH-1:0] redirectTarget,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic             pcEpoch,
    output logic             fetchValid,
    output logic             flush,
    output logic             misaligned,
    output logic [31:0]      fetchCount,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE, RUN, REDIRECT, HALT} state_t;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] LOW  = WIDTH'(INSTR_BYTES - 1);

    state_t           cur, nxt;
    logic [WIDTH-1:0] pc_d;
    logic [31:0]      cnt_d;
    logic             accept;

    assign state = cur;

    // Redirect wins over everything once the sequencer has left IDLE.
    always_comb begin
        nxt    = cur;
        pc_d   = pc;
        cnt_d  = fetchCount;
        accept = redirectValid && (cur != IDLE);
        if (accept) begin
            nxt  = REDIRECT;
            pc_d = redirectTarget & ~LOW;
        end else begin
            case (cur)
                IDLE:     nxt = start ? RUN : IDLE;
                RUN: begin
                    if (halt) begin
                        nxt = HALT;
                    end else if (!stall) begin
                        pc_d  = pc + STEP;
                        cnt_d = fetchCount + 32'd1;
                    end
                end
                REDIRECT: nxt = RUN;
                HALT:     nxt = start ? RUN : HALT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur        <= IDLE;
            pc         <= RESET_PC;
            pcEpoch    <= 1'b0;
            fetchValid <= 1'b0;
            flush      <= 1'b0;
            misaligned <= 1'b0;
            fetchCount <= '0;
        end else begin
            cur        <= nxt;
            pc         <= pc_d;
            pcEpoch    <= pcEpoch ^ accept;
            fetchValid <= (nxt == RUN);
            flush      <= accept;
            misaligned <= accept && |(redirectTarget & LOW);
            fetchCount <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, randomized run against a rule-level model, and async reset corner.
module tb_fetch_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, stall = 1'b0, redirectValid = 1'b0, halt = 1'b0;
    logic [31:0] redirectTarget = '0;
    logic [31:0] pc, fetchCount;
    logic        pcEpoch, fetchValid, flush, misaligned;
    logic [1:0]  state;

    fetch_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .redirectValid(redirectValid), .redirectTarget(redirectTarget), .halt(halt),
        .pc(pc), .pcEpoch(pcEpoch), .fetchValid(fetchValid), .flush(flush),
        .misaligned(misaligned), .fetchCount(fetchCount), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        st, sl, rv, hl;
        logic [31:0] tg;
        logic [1:0]  e_state;
        logic [31:0] e_pc;
        logic        e_fv, e_fl, e_mis, e_ep;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: the fetch stage as a mode plus an address, updated by the rules directly.
    int          m_mode;
    logic [31:0] m_pc, m_cnt;
    logic        m_ep, m_fl, m_mis;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_ep = 0; m_fl = 0; m_mis = 0;
    endtask

    task automatic model_step(input logic st, sl, rv, input logic [31:0] tg, input logic hl);
        bit acc = rv && (m_mode != 0);
        m_fl  = acc;
        m_mis = acc && (tg % 4 != 0);
        if (acc) begin
            m_pc   = tg - (tg % 4);
            m_ep   = !m_ep;
            m_mode = 2;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (st) m_mode = 1;
        end else if (m_mode == 2) begin
            m_mode = 1;
        end else if (hl) begin
            m_mode = 3;
        end else if (!sl) begin
            m_pc  = m_pc + 4;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, 32'(state), 32'(m_mode));
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_fv"}, 32'(fetchValid), 32'(m_mode == 1));
        check({tag, "_flush"}, 32'(flush), 32'(m_fl));
        check({tag, "_mis"}, 32'(misaligned), 32'(m_mis));
        check({tag, "_epoch"}, 32'(pcEpoch), 32'(m_ep));
        check({tag, "_cnt"}, fetchCount, m_cnt);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_fv"}, 32'(fetchValid), 0);
        check({tag, "_flush"}, 32'(flush), 0);
        check({tag, "_mis"}, 32'(misaligned), 0);
        check({tag, "_epoch"}, 32'(pcEpoch), 0);
        check({tag, "_cnt"}, fetchCount, 0);
    endtask

    task automatic apply(input logic st, sl, rv, input logic [31:0] tg, input logic hl);
        start = st; stall = sl; redirectValid = rv; redirectTarget = tg; halt = hl;
        @(posedge clock);
        #1;
        model_step(st, sl, rv, tg, hl);
    endtask

    task automatic add(input logic st, sl, rv, input logic [31:0] tg, input logic hl,
                       input logic [1:0] es, input logic [31:0] ep, input logic efv, efl, emis, eep,
                       input logic [31:0] ec);
        vec_t v;
        v.st = st; v.sl = sl; v.rv = rv; v.tg = tg; v.hl = hl;
        v.e_state = es; v.e_pc = ep; v.e_fv = efv; v.e_fl = efl; v.e_mis = emis; v.e_ep = eep; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        //  st sl rv target        hl  state pc           fv fl ms ep cnt
        add(1, 0, 0, 0,            0,  1, 32'h0,        1, 0, 0, 0, 0);
        add(0, 0, 0, 0,            0,  1, 32'h4,        1, 0, 0, 0, 1);
        add(0, 0, 0, 0,            0,  1, 32'h8,        1, 0, 0, 0, 2);
        add(0, 0, 0, 0,            0,  1, 32'hC,        1, 0, 0, 0, 3);
        add(0, 0, 1, 32'h10,       0,  2, 32'h10,       0, 1, 0, 1, 3);
        add(0, 1, 0, 0,            0,  1, 32'h10,       1, 0, 0, 1, 3);
        add(0, 1, 0, 0,            0,  1, 32'h10,       1, 0, 0, 1, 3);
        add(0, 1, 0, 0,            0,  1, 32'h10,       1, 0, 0, 1, 3);
        add(0, 0, 0, 0,            0,  1, 32'h14,       1, 0, 0, 1, 4);
        add(0, 0, 1, 32'h20,       0,  2, 32'h20,       0, 1, 0, 0, 4);
        add(0, 0, 0, 0,            0,  1, 32'h20,       1, 0, 0, 0, 4);
        add(0, 1, 1, 32'h102,      0,  2, 32'h100,      0, 1, 1, 1, 4);
        add(0, 0, 0, 0,            0,  1, 32'h100,      1, 0, 0, 1, 4);
        add(0, 0, 1, 32'h40,       0,  2, 32'h40,       0, 1, 0, 0, 4);
        add(0, 0, 1, 32'h80,       0,  2, 32'h80,       0, 1, 0, 1, 4);
        add(0, 0, 0, 0,            0,  1, 32'h80,       1, 0, 0, 1, 4);
        add(0, 0, 1, 32'h30,       0,  2, 32'h30,       0, 1, 0, 0, 4);
        add(0, 0, 0, 0,            0,  1, 32'h30,       1, 0, 0, 0, 4);
        add(0, 0, 0, 0,            1,  3, 32'h30,       0, 0, 0, 0, 4);
        add(0, 0, 0, 0,            1,  3, 32'h30,       0, 0, 0, 0, 4);
        add(0, 0, 1, 32'h50,       0,  2, 32'h50,       0, 1, 0, 1, 4);
        add(0, 0, 0, 0,            0,  1, 32'h50,       1, 0, 0, 1, 4);
        add(0, 0, 1, 32'h30,       0,  2, 32'h30,       0, 1, 0, 0, 4);
        add(0, 0, 0, 0,            0,  1, 32'h30,       1, 0, 0, 0, 4);
        add(0, 0, 0, 0,            1,  3, 32'h30,       0, 0, 0, 0, 4);
        add(0, 0, 0, 0,            0,  3, 32'h30,       0, 0, 0, 0, 4);
        add(1, 0, 0, 0,            0,  1, 32'h30,       1, 0, 0, 0, 4);
        add(0, 0, 0, 0,            0,  1, 32'h34,       1, 0, 0, 0, 5);
        add(0, 0, 1, 32'hFFFFFFFF, 0,  2, 32'hFFFFFFFC, 0, 1, 1, 1, 5);
        add(0, 0, 0, 0,            0,  1, 32'hFFFFFFFC, 1, 0, 0, 1, 5);
        add(0, 0, 0, 0,            0,  1, 32'h0,        1, 0, 0, 1, 6);
        add(1, 1, 0, 0,            1,  3, 32'h0,        0, 0, 0, 1, 6);
        add(1, 0, 1, 32'h8,        1,  2, 32'h8,        0, 1, 0, 0, 6);
        add(0, 1, 0, 0,            0,  1, 32'h8,        1, 0, 0, 0, 6);

        model_reset();
        #3;
        check_reset_vals("reset");
        apply(0, 0, 1, 32'h44, 1);
        check_reset_vals("idle_ignore");
        #2 reset = 1'b1;
        apply(0, 0, 1, 32'h44, 1);
        check_reset_vals("idle_rv");

        foreach (vecs[i]) begin
            apply(vecs[i].st, vecs[i].sl, vecs[i].rv, vecs[i].tg, vecs[i].hl);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("vec%0d_fv", i), 32'(fetchValid), 32'(vecs[i].e_fv));
            check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_fl));
            check($sformatf("vec%0d_mis", i), 32'(misaligned), 32'(vecs[i].e_mis));
            check($sformatf("vec%0d_epoch", i), 32'(pcEpoch), 32'(vecs[i].e_ep));
            check($sformatf("vec%0d_cnt", i), fetchCount, vecs[i].e_cnt);
        end

        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
                  $urandom, $urandom_range(7) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        apply(1, 0, 0, 0, 0);
        apply(0, 0, 1, 32'h1237, 0);
        check_model("pre_rst");
        #2 reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        #2 reset = 1'b1;
        apply(0, 0, 0, 0, 0);
        check_model("post_rst");
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        check_model("post_rst_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
